// File: rtl/sma_ds2_ch_sched_if.sv
// Bundle for the multi-channel moving-average scheduler:
// per-channel sample requests in, one channel-tagged result stream out.
interface sma_ds2_ch_sched_if #(
  parameter int NUM_CH = 4,
  parameter int DW     = 16,
  parameter int CW     = 2
);
  logic [NUM_CH-1:0]    ch_en;
  logic [NUM_CH-1:0]    ch_clr;
  logic [NUM_CH-1:0]    in_valid;
  logic [NUM_CH*DW-1:0] in_data;
  logic [NUM_CH-1:0]    in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [CW-1:0]        out_ch;

  modport master (
    output ch_en, ch_clr, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  ch_en, ch_clr, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/sma_ds2_ch_sched.sv
// Round-robin scheduler sharing one 4-tap moving-average
// datapath (pairwise-sum split) across NUM_CH channels.
module sma_ds2_ch_sched #(
  parameter int NUM_CH = 4,
  parameter int DW     = 16,
  parameter int CW     = 2
) (
  input logic               clk,
  input logic               rst,
  sma_ds2_ch_sched_if.slave bus
);

  logic signed [DW-1:0] x1_q   [NUM_CH];
  logic signed [DW:0]   s0_1_q [NUM_CH];
  logic signed [DW:0]   s2_q   [NUM_CH];

  logic          ov_q;
  logic [DW-1:0] od_q;
  logic [CW-1:0] oc_q;
  logic [CW-1:0] rr_q;
  logic [CW-1:0] rr_d;

  logic [NUM_CH-1:0] elig;
  logic              any_el;
  logic              can_acc;
  logic              xfer;
  logic [CW-1:0]     gnt;
  int                idx;

  always_comb begin
    elig   = bus.in_valid & bus.ch_en;
    any_el = 1'b0;
    gnt    = '0;
    idx    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any_el && elig[idx]) begin
        any_el = 1'b1;
        gnt    = CW'(idx);
      end
    end
  end

  assign can_acc = !ov_q || bus.out_ready;
  assign xfer    = can_acc && any_el && !rst;
  assign rr_d    = (gnt == CW'(NUM_CH - 1)) ? '0 : gnt + 1'b1;

  assign bus.in_ready = xfer ? (NUM_CH'(1) << gnt) : '0;

  logic signed [DW-1:0] x;
  logic signed [DW-1:0] hx1;
  logic signed [DW:0]   hs01;
  logic signed [DW:0]   hs2;
  logic signed [DW:0]   s0;
  logic signed [DW+1:0] sum;
  logic [DW-1:0]        q;

  // A same-cycle clear makes the sample see an all-zero history
  always_comb begin
    x    = bus.in_data[int'(gnt)*DW +: DW];
    hx1  = bus.ch_clr[gnt] ? '0 : x1_q[gnt];
    hs01 = bus.ch_clr[gnt] ? '0 : s0_1_q[gnt];
    hs2  = bus.ch_clr[gnt] ? '0 : s2_q[gnt];
    s0   = {x[DW-1], x} + {hx1[DW-1], hx1};
    sum  = {s0[DW], s0} + {hs2[DW], hs2};
    // Floor shift, bumped by one for negative non-exact sums
    q    = sum[DW+1:2]
         + {{(DW-1){1'b0}}, sum[DW+1] & (|sum[1:0])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q <= 1'b0;
      od_q <= '0;
      oc_q <= '0;
      rr_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        x1_q[c]   <= '0;
        s0_1_q[c] <= '0;
        s2_q[c]   <= '0;
      end
    end else begin
      if (xfer) begin
        ov_q <= 1'b1;
        od_q <= q;
        oc_q <= gnt;
        rr_q <= rr_d;
      end else if (bus.out_ready) begin
        ov_q <= 1'b0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (xfer && gnt == CW'(c)) begin
          x1_q[c]   <= x;
          s0_1_q[c] <= s0;
          s2_q[c]   <= hs01;
        end else if (bus.ch_clr[c]) begin
          x1_q[c]   <= '0;
          s0_1_q[c] <= '0;
          s2_q[c]   <= '0;
        end
      end
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_ch    = oc_q;

endmodule

// File: tb/tb_sma_ds2_ch_sched.sv
// Bench for sma_ds2_ch_sched: cycle model of arbiter and
// raw 4-sample history, results queued and checked in order.
module tb_sma_ds2_ch_sched;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sma_ds2_ch_sched_if #(.NUM_CH(N), .DW(DW), .CW(CW)) bus ();

  sma_ds2_ch_sched #(.NUM_CH(N), .DW(DW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int c;
    int d;
  } res_t;

  res_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int h[N][3];
  int m_rr = 0;
  int m_ov = 0;
  int m_od = 0;
  int m_oc = 0;

  task automatic chk(input string tag,
                     input logic signed [31:0] got,
                     input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int g;
    int idx;
    int x;
    int sum;
    logic can;
    logic [N-1:0] exp_rdy;
    chk("out_valid", int'(bus.out_valid), m_ov);
    if (m_ov != 0) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        chk("out_data", $signed(bus.out_data), sb[0].d);
        chk("out_ch", int'(bus.out_ch), sb[0].c);
      end
    end else begin
      chk("hold_data", $signed(bus.out_data), m_od);
      chk("hold_ch", int'(bus.out_ch), m_oc);
    end
    can = (m_ov == 0) || bus.out_ready;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      if (g < 0 && bus.in_valid[idx] && bus.ch_en[idx]) g = idx;
    end
    exp_rdy = (rst || !can || g < 0) ? '0 : (N'(1) << g);
    chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
    if (rst) begin
      m_ov = 0; m_rr = 0; m_od = 0; m_oc = 0;
      sb.delete();
      for (int c = 0; c < N; c++)
        for (int j = 0; j < 3; j++) h[c][j] = 0;
    end else begin
      if (m_ov != 0 && bus.out_ready && sb.size() > 0)
        void'(sb.pop_front());
      for (int c = 0; c < N; c++)
        if (bus.ch_clr[c])
          for (int j = 0; j < 3; j++) h[c][j] = 0;
      if (exp_rdy != 0) begin
        x   = int'($signed(bus.in_data[g*DW +: DW]));
        sum = x + h[g][0] + h[g][1] + h[g][2];
        sb.push_back('{c: g, d: sum / 4});
        m_od = sum / 4;
        m_oc = g;
        h[g][2] = h[g][1];
        h[g][1] = h[g][0];
        h[g][0] = x;
        m_rr = (g + 1) % N;
        m_ov = 1;
      end else if (bus.out_ready) begin
        m_ov = 0;
      end
    end
  end

  task automatic drive(input logic [N-1:0] en,
                       input logic [N-1:0] clr,
                       input logic [N-1:0] vld,
                       input int d0, input int d1,
                       input int d2, input int d3,
                       input logic ordy,
                       input logic r);
    bus.ch_en     = en;
    bus.ch_clr    = clr;
    bus.in_valid  = vld;
    bus.in_data   = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    bus.out_ready = ordy;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 2000)) - 1000;
  endfunction

  initial begin
    drive(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 1'b1, 1'b1);
    drive(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 1'b1, 1'b1);
    drive(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 1'b1, 1'b0);
    repeat (5) drive(4'hF, 4'h0, 4'h1, 100, 0, 0, 0, 1'b1, 1'b0);
    drive(4'hF, 4'h0, 4'h2, 0, -1, 0, 0, 1'b1, 1'b0);
    drive(4'hF, 4'h0, 4'h2, 0, -2, 0, 0, 1'b1, 1'b0);
    drive(4'hF, 4'h0, 4'h2, 0, -3, 0, 0, 1'b1, 1'b0);
    drive(4'hF, 4'h0, 4'h2, 0, -4, 0, 0, 1'b1, 1'b0);
    drive(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 1'b1, 1'b0);
    repeat (8) drive(4'hF, 4'h0, 4'hF, rnd(), rnd(), rnd(), rnd(), 1'b1, 1'b0);
    repeat (6) drive(4'hB, 4'h0, 4'hF, rnd(), rnd(), rnd(), rnd(), 1'b1, 1'b0);
    drive(4'hF, 4'h1, 4'h0, 0, 0, 0, 0, 1'b1, 1'b0);
    repeat (4) drive(4'hF, 4'h0, 4'h1, -32768, 0, 0, 0, 1'b1, 1'b0);
    repeat (4) drive(4'hF, 4'h0, 4'h1, 32767, 0, 0, 0, 1'b1, 1'b0);
    drive(4'hF, 4'h0, 4'hF, rnd(), rnd(), rnd(), rnd(), 1'b1, 1'b0);
    repeat (3) drive(4'hF, 4'h0, 4'hF, rnd(), rnd(), rnd(), rnd(), 1'b0, 1'b0);
    repeat (3) drive(4'hF, 4'h0, 4'hF, rnd(), rnd(), rnd(), rnd(), 1'b1, 1'b0);
    drive(4'hF, 4'h4, 4'h0, 0, 0, 0, 0, 1'b1, 1'b0);
    repeat (3) drive(4'hF, 4'h0, 4'h4, 0, 0, 40, 0, 1'b1, 1'b0);
    drive(4'hF, 4'h4, 4'h4, 0, 0, 40, 0, 1'b1, 1'b0);
    drive(4'hF, 4'h0, 4'hF, 5, 6, 7, 9, 1'b1, 1'b0);
    drive(4'hF, 4'h0, 4'hF, 5, 6, 7, 9, 1'b0, 1'b1);
    drive(4'hF, 4'h0, 4'h1, 8, 0, 0, 0, 1'b1, 1'b0);
    repeat (3) drive(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 1'b1, 1'b0);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
